// File: rtl/regfile_pkg.sv
// Shared defaults and the packed-port slicing helper for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int NUM_RD_DEF = 2;

  // Low bit of field idx inside a vector of back-to-back fields of width w.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address mux over the flattened storage,
// optional same-cycle write forwarding, and hold while not enabled.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                    clk,
  input  logic                    sync_rst,
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DEPTH-1:0]        busy_next,
  output logic [DATA_W-1:0]       data,
  output logic                    busy_bit
);

  logic [DATA_W-1:0] sel_s;
  logic [DATA_W-1:0] data_r;
  logic              busy_r;

  // Pick stored value, or the in-flight write when forwarding is enabled.
  always_comb begin
    sel_s = mem_flat[slice_lo(32'(addr), DATA_W) +: DATA_W];
    if ((BYPASS != 32'sd0) && wr_en && (wr_addr == addr)) begin
      sel_s = wr_data;
    end else begin
      sel_s = mem_flat[slice_lo(32'(addr), DATA_W) +: DATA_W];
    end
  end

  // Capture data and post-edge pending bit on enable; hold otherwise.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      data_r <= {DATA_W{1'b0}};
      busy_r <= 1'b0;
    end else if (en) begin
      data_r <= sel_s;
      busy_r <= busy_next[addr];
    end
  end

  assign data     = data_r;
  assign busy_bit = busy_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending (scoreboard) bit.
// Storage, write path and scoreboard live here; read ports are sub-modules.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     sync_rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       mem_r [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat_s;
  logic [DEPTH-1:0]        busy_r;
  logic [DEPTH-1:0]        busy_next_s;
  logic                    wr_eff_s;
  logic                    sb_eff_s;

  // Register 0 absorbs writes and never goes pending when hardwired to zero.
  always_comb begin
    wr_eff_s = wr_en;
    sb_eff_s = sb_set;
    if ((ZERO_R0 != 32'sd0) && (wr_addr == {ADDR_W{1'b0}})) begin
      wr_eff_s = 1'b0;
    end else begin
      wr_eff_s = wr_en;
    end
    if ((ZERO_R0 != 32'sd0) && (sb_addr == {ADDR_W{1'b0}})) begin
      sb_eff_s = 1'b0;
    end else begin
      sb_eff_s = sb_set;
    end
  end

  // Next scoreboard: a new producer wins over a completing write to the same register.
  always_comb begin
    busy_next_s = busy_r;
    for (int n = 0; n < DEPTH; n++) begin
      if (sb_eff_s && (sb_addr == ADDR_W'(n))) begin
        busy_next_s[n] = 1'b1;
      end else if (wr_eff_s && (wr_addr == ADDR_W'(n))) begin
        busy_next_s[n] = 1'b0;
      end else begin
        busy_next_s[n] = busy_r[n];
      end
    end
  end

  // Register storage write port.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_r[n] <= {DATA_W{1'b0}};
      end
    end else if (wr_eff_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Scoreboard flops; busy is driven straight from these.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy = busy_r;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat_s[slice_lo(g, DATA_W) +: DATA_W] = mem_r[g];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS),
      .DEPTH  (DEPTH)
    ) u_port (
      .clk       (clk),
      .sync_rst  (sync_rst),
      .en        (rd_en[i]),
      .addr      (rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]),
      .mem_flat  (mem_flat_s),
      .wr_en     (wr_eff_s),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy_next (busy_next_s),
      .data      (rd_data[slice_lo(i, DATA_W) +: DATA_W]),
      .busy_bit  (rd_busy[i])
    );
  end

endmodule
